// File: rtl/vga_80x60_scanner.sv
// rtl/vga_80x60_scanner.sv - 640x480@60 VGA scanner over an 80x60 8-bit framebuffer
module vga_80x60_scanner #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int SCALE_SHIFT = 3
) (
  input  logic        CLK_50MHz,
  input  logic        RST,
  output logic [12:0] RA2,
  input  logic [7:0]  RD2,
  output logic [7:0]  VGA_RGB,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pix_en_q, pix_en_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic [7:0] rgb_q, rgb_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q, fs_d;

  logic        visible;
  logic [12:0] row_base;
  logic [12:0] col_off;

  // Framebuffer address from the live counters; blanking parks the address at 0
  always_comb begin
    visible  = (h_q < H_VIS) && (v_q < V_VIS);
    row_base = 13'(v_q >> SCALE_SHIFT) << 7;
    col_off  = 13'(h_q >> SCALE_SHIFT);
    RA2      = visible ? (row_base | col_off) : 13'd0;
  end

  // Pixel-rate counter advance and output sampling of the pre-increment position
  always_comb begin
    pix_en_d = ~pix_en_q;
    h_d      = h_q;
    v_d      = v_q;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    fs_d     = 1'b0;
    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      rgb_d = visible ? RD2 : 8'h00;
      hs_d  = !((h_q >= HS_START) && (h_q < HS_END));
      vs_d  = !((v_q >= VS_START) && (v_q < VS_END));
      fs_d  = (h_q == 10'd0) && (v_q == 10'd0);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK_50MHz) begin
    if (RST) begin
      pix_en_q <= 1'b0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      rgb_q    <= 8'h00;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      h_q      <= h_d;
      v_q      <= v_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
    end
  end

  assign VGA_RGB     = rgb_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_80x60_scanner.sv
// tb/tb_vga_80x60_scanner.sv - directed bench for vga_80x60_scanner
module tb_vga_80x60_scanner;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        fill_ff;
  logic [12:0] ra2_a, ra2_b;
  logic [7:0]  rd2_a, rd2_b;
  logic [7:0]  rgb_a, rgb_b;
  logic        hs_a, hs_b, vs_a, vs_b, fs_a, fs_b;
  int          k_a, k_b;
  int          checks = 0;
  int          failures = 0;

  always #10 clk = ~clk;

  // RAM model: mem[a] = a[7:0], or all 8'hFF when filled
  assign rd2_a = fill_ff ? 8'hFF : ra2_a[7:0];
  assign rd2_b = 8'hFF;

  vga_80x60_scanner dut_a (
    .CLK_50MHz(clk), .RST(rst_a), .RA2(ra2_a), .RD2(rd2_a),
    .VGA_RGB(rgb_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .FRAME_START(fs_a)
  );

  // Reduced timing: 24 pixels/line, 14 lines/frame, 672 clocks/frame
  vga_80x60_scanner #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SCALE_SHIFT(3)
  ) dut_b (
    .CLK_50MHz(clk), .RST(rst_b), .RA2(ra2_b), .RD2(rd2_b),
    .VGA_RGB(rgb_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .FRAME_START(fs_b)
  );

  // Clocks elapsed since the last edge that saw reset asserted
  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + 1;
    k_b <= rst_b ? 0 : k_b + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_a(input int n);
    while (k_a < n) @(negedge clk);
  endtask

  task automatic wait_b(input int n);
    while (k_b < n) @(negedge clk);
  endtask

  typedef struct {
    int h;
    int v;
    int ra2;
    int rgb;
    int hs;
  } vec_t;

  vec_t vecs[15];

  int fs_cnt_a = 0;
  int fs_first_a = -1;

  // Frame-start monitor for the full-size scanner
  always @(negedge clk) begin
    if (!rst_a && fs_a === 1'b1) begin
      if (fs_first_a < 0) fs_first_a = k_a;
      fs_cnt_a++;
    end
  end

  initial begin
    int ff_cnt, hs_low, ff_first, hs_first, vs_low, vs_first, fs_cnt;
    int fs_cyc[4];

    vecs[0]  = '{h:0,   v:0,  ra2:0,   rgb:0,   hs:1};
    vecs[1]  = '{h:7,   v:0,  ra2:0,   rgb:0,   hs:1};
    vecs[2]  = '{h:8,   v:0,  ra2:1,   rgb:1,   hs:1};
    vecs[3]  = '{h:639, v:0,  ra2:79,  rgb:79,  hs:1};
    vecs[4]  = '{h:640, v:0,  ra2:0,   rgb:0,   hs:1};
    vecs[5]  = '{h:655, v:0,  ra2:0,   rgb:0,   hs:1};
    vecs[6]  = '{h:656, v:0,  ra2:0,   rgb:0,   hs:0};
    vecs[7]  = '{h:751, v:0,  ra2:0,   rgb:0,   hs:0};
    vecs[8]  = '{h:752, v:0,  ra2:0,   rgb:0,   hs:1};
    vecs[9]  = '{h:799, v:0,  ra2:0,   rgb:0,   hs:1};
    vecs[10] = '{h:0,   v:1,  ra2:0,   rgb:0,   hs:1};
    vecs[11] = '{h:8,   v:8,  ra2:129, rgb:129, hs:1};
    vecs[12] = '{h:639, v:8,  ra2:207, rgb:207, hs:1};
    vecs[13] = '{h:100, v:9,  ra2:140, rgb:140, hs:1};
    vecs[14] = '{h:640, v:10, ra2:0,   rgb:0,   hs:1};

    fill_ff = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_rgb", int'(rgb_a), 0);
    check("reset_hs", int'(hs_a), 1);
    check("reset_vs", int'(vs_a), 1);
    check("reset_fs", int'(fs_a), 0);
    check("reset_ra2", int'(ra2_a), 0);
    check("reset_b_hs", int'(hs_b), 1);
    @(posedge clk);
    #1 rst_a = 1'b0;

    // Pixel p=v*800+h: address valid in cycle 2p+1, registered sample in cycle 2p+2
    for (int i = 0; i < 15; i++) begin
      int p;
      p = vecs[i].v * 800 + vecs[i].h;
      wait_a(2 * p + 1);
      check($sformatf("ra2_h%0d_v%0d", vecs[i].h, vecs[i].v), int'(ra2_a), vecs[i].ra2);
      wait_a(2 * p + 2);
      check($sformatf("rgb_h%0d_v%0d", vecs[i].h, vecs[i].v), int'(rgb_a), vecs[i].rgb);
      check($sformatf("hs_h%0d_v%0d", vecs[i].h, vecs[i].v), int'(hs_a), vecs[i].hs);
      check($sformatf("vs_h%0d_v%0d", vecs[i].h, vecs[i].v), int'(vs_a), 1);
    end
    check("fs_first_cycle", fs_first_a, 2);

    // Full line 11 with an all-FF framebuffer
    wait_a(2 * 8800);
    fill_ff = 1'b1;
    ff_cnt = 0; hs_low = 0; ff_first = -1; hs_first = -1;
    for (int n = 2 * 8800 + 2; n <= 2 * 9600 + 1; n++) begin
      wait_a(n);
      if (rgb_a == 8'hFF) begin
        ff_cnt++;
        if (ff_first < 0) ff_first = n;
      end
      if (hs_a == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
    end
    fill_ff = 1'b0;
    check("line_ff_clocks", ff_cnt, 1280);
    check("line_ff_start", ff_first, 2 * 8800 + 2);
    check("line_hs_low_clocks", hs_low, 192);
    check("hs_fall_offset", hs_first - ff_first, 1312);
    check("fs_count_a", fs_cnt_a, 1);

    // Reduced-timing scanner: frame period, vsync and blanking
    @(posedge clk);
    #1 rst_b = 1'b0;
    ff_cnt = 0; vs_low = 0; vs_first = -1; fs_cnt = 0;
    for (int n = 1; n <= 1345; n++) begin
      wait_b(n);
      if (fs_b == 1'b1) begin
        if (fs_cnt < 4) fs_cyc[fs_cnt] = n;
        fs_cnt++;
      end
      if (vs_b == 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = n;
      end
      if (rgb_b == 8'hFF) ff_cnt++;
    end
    check("b_fs_count", fs_cnt, 2);
    check("b_fs_first", fs_cyc[0], 2);
    check("b_frame_period", fs_cyc[1] - fs_cyc[0], 672);
    check("b_vs_low_clocks", vs_low, 192);
    check("b_vs_offset", vs_first - fs_cyc[0], 480);
    check("b_visible_clocks", ff_cnt, 512);
    wait_b(1346);
    check("b_fs_third", int'(fs_b), 1);

    // Mid-frame reset at h=10,v=5 of the third frame
    wait_b(1344 + 2 * 130 + 1);
    check("b_ra2_mid", int'(ra2_b), 1);
    rst_b = 1'b1;
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    check("mid_rst_rgb", int'(rgb_b), 0);
    check("mid_rst_hs", int'(hs_b), 1);
    check("mid_rst_vs", int'(vs_b), 1);
    check("mid_rst_fs", int'(fs_b), 0);
    check("mid_rst_ra2", int'(ra2_b), 0);
    fs_cnt = 0;
    for (int n = 1; n <= 674; n++) begin
      wait_b(n);
      if (fs_b == 1'b1) begin
        if (fs_cnt < 4) fs_cyc[fs_cnt] = n;
        fs_cnt++;
      end
      if (n == 2) check("mid_rst_first_rgb", int'(rgb_b), 255);
    end
    check("mid_rst_fs_count", fs_cnt, 2);
    check("mid_rst_fs_first", fs_cyc[0], 2);
    check("mid_rst_period", fs_cyc[1] - fs_cyc[0], 672);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
